// File: rtl/feat_bram_reader_pkg.sv
// Shared GAT feature-reader definitions: FSM state encoding, feature word width
// and the word-to-byte address helper used by all BRAM port drivers.
package feat_bram_reader_pkg;

  localparam int NEW_FEATURE_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } feat_rd_state_t;

  // BRAM ports are byte addressed; feature words are 4 bytes.
  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
    return word_idx << 2;
  endfunction

endpackage

// File: rtl/feat_bram_reader_if.sv
// Feature BRAM read port plus AXI4-Stream output of the feature reader.
// master: reader side; slave: BRAM model / stream sink side.
interface feat_bram_reader_if
  import feat_bram_reader_pkg::*;
#(
  parameter int DATA_W      = NEW_FEATURE_WIDTH,
  parameter int BYTE_ADDR_W = 18
);
  logic [BYTE_ADDR_W-1:0] feat_bram_addrb;
  logic [DATA_W-1:0]      feat_bram_dout;
  logic [DATA_W-1:0]      m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;

  modport master (
    output feat_bram_addrb,
    input  feat_bram_dout,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport slave (
    input  feat_bram_addrb,
    output feat_bram_dout,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );
endinterface

// File: rtl/feat_bram_reader_fifo.sv
// feat_rd_fifo: small synchronous FIFO with register-array storage; the head
// entry is presented directly from storage, so no read latency.
module feat_rd_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is accepted only when a pop frees the slot.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_rd)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/feat_bram_reader.sv
// Streams one frame of final-layer features from the feature BRAM to AXI4-Stream.
// FEAT_RD_ROW_LAST_EN: tlast per node row instead of once per frame.
//
// state    | meaning
// ST_IDLE  | waiting for start, addrb parked at 0
// ST_READ  | issuing reads under FIFO credit
// ST_DRAIN | all reads issued, emptying pipeline and FIFO
module feat_bram_reader
  import feat_bram_reader_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = feat_bram_reader_pkg::NEW_FEATURE_WIDTH,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  feat_bram_reader_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(BRAM_RD_LATENCY + 1);
  localparam int AW    = NEW_FEATURE_ADDR_W;

  feat_rd_state_t         state;
  feat_rd_state_t         state_nxt;
  logic [AW-1:0]          idx;
  logic [AW-1:0]          beat_cnt;
  logic [BRAM_RD_LATENCY-1:0] vld_sr;
  logic [INF_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   last_beat;

  assign inflight  = INF_W'($countones(vld_sr));
  // Credit counts pending reads as occupied so the FIFO can never overflow.
  assign issue     = (state == ST_READ) &&
                     ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));
  assign push      = vld_sr[BRAM_RD_LATENCY-1];
  assign pop       = !fifo_empty && bus.m_axis_tready;
  assign last_beat = (beat_cnt == AW'(NEW_FEATURE_DEPTH - 1));
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (issue && (idx == AW'(NEW_FEATURE_DEPTH - 1))) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && (fifo_count == CNT_W'(1)) && pop && last_beat)
                  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      vld_sr   <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done   <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
      vld_sr <= (vld_sr << 1) | BRAM_RD_LATENCY'(issue);
      if ((state == ST_IDLE) && start) idx <= '0;
      else if (issue)                  idx <= idx + AW'(1);
      if (pop) beat_cnt <= last_beat ? '0 : beat_cnt + AW'(1);
    end
  end

  assign bus.feat_bram_addrb = (state == ST_READ) ?
                               (AW + 2)'(word_to_byte_addr(32'(idx))) : '0;
  assign bus.m_axis_tvalid   = !fifo_empty;

`ifdef FEAT_RD_ROW_LAST_EN
  localparam int ROW_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  logic [ROW_W-1:0] row_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      row_cnt <= '0;
    else if (pop) row_cnt <= (row_cnt == ROW_W'(NUM_FEATURE_OUT - 1)) ? '0 : row_cnt + ROW_W'(1);
  end

  assign bus.m_axis_tlast = !fifo_empty && (row_cnt == ROW_W'(NUM_FEATURE_OUT - 1));
`else
  assign bus.m_axis_tlast = !fifo_empty && last_beat;
`endif

  feat_rd_fifo #(
    .DATA_W (NEW_FEATURE_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (bus.feat_bram_dout),
    .rd_en   (pop),
    .rd_data (bus.m_axis_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule
